// File: rtl/mode_counter_if.sv
// rtl/mode_counter_if.sv - control/status bundle for mode_counter
// Optional cnt_gray member exists only when GRAY_OUT_EN is defined.
interface mode_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up_dn;
  logic [1:0]       mode;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             wrap;
  logic             done;
`ifdef GRAY_OUT_EN
  logic [WIDTH-1:0] cnt_gray;
`endif

`ifdef GRAY_OUT_EN
  modport master (
    output en, load, load_val, up_dn, mode,
    input  cnt, tc, wrap, done, cnt_gray
  );

  modport slave (
    input  en, load, load_val, up_dn, mode,
    output cnt, tc, wrap, done, cnt_gray
  );
`else
  modport master (
    output en, load, load_val, up_dn, mode,
    input  cnt, tc, wrap, done
  );

  modport slave (
    input  en, load, load_val, up_dn, mode,
    output cnt, tc, wrap, done
  );
`endif
endinterface

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - synchronous up/down counter with free-run, one-shot and ping-pong modes
// Optional registered Gray-code output enabled by GRAY_OUT_EN.
module mode_counter #(
  parameter int WIDTH = 8,
  parameter int MOD   = 2**WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  mode_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    M_FREE    = 2'b00,
    M_ONESHOT = 2'b01,
    M_PING    = 2'b10,
    M_RSVD    = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MODV = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             dir_up_q, dir_up_d;
  logic             eff_up;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] load_sat;
  mode_t            mode;

  assign mode     = mode_t'(bus.mode);
  assign eff_up   = (mode == M_PING) ? dir_up_q : bus.up_dn;
  assign term     = eff_up ? MAXV : ZERO;
  assign load_sat = ({1'b0, bus.load_val} < MODV) ? bus.load_val : MAXV;

  always_comb begin
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    done_d   = done_q;
    dir_up_d = dir_up_q;

    if (bus.load) begin
      cnt_d  = load_sat;
      done_d = 1'b0;
    end else if (bus.en && !done_q) begin
      // done_q freezes every mode, so leaving one-shot after completion stays frozen
      case (mode)
        M_ONESHOT: begin
          if (cnt_q == term) begin
            done_d = 1'b1;
          end else begin
            cnt_d = eff_up ? cnt_q + ONE : cnt_q - ONE;
          end
        end
        M_PING: begin
          if (dir_up_q && cnt_q == MAXV) begin
            cnt_d    = MAXV - ONE;
            dir_up_d = 1'b0;
            wrap_d   = 1'b1;
          end else if (!dir_up_q && cnt_q == ZERO) begin
            cnt_d    = ONE;
            dir_up_d = 1'b1;
            wrap_d   = 1'b1;
          end else begin
            cnt_d = dir_up_q ? cnt_q + ONE : cnt_q - ONE;
          end
        end
        default: begin
          if (eff_up) begin
            if (cnt_q == MAXV) begin
              cnt_d  = ZERO;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end else begin
            if (cnt_q == ZERO) begin
              cnt_d  = MAXV;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      dir_up_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.wrap = wrap_q;
  assign bus.done = done_q;
  assign bus.tc   = (cnt_q == term);

`ifdef GRAY_OUT_EN
  logic [WIDTH-1:0] gray_q;

  // Encoded from cnt_d so the Gray value lands in the same cycle as cnt
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= '0;
    end else begin
      gray_q <= cnt_d ^ (cnt_d >> 1);
    end
  end

  assign bus.cnt_gray = gray_q;
`endif

endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - self-checking bench for mode_counter (MOD=10 and MOD=4 instances)
// Integer reference model checked every cycle, plus hand-computed literal checkpoints.
module tb_mode_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       up_dn;
  logic [1:0] mode;

  int checks   = 0;
  int failures = 0;

  mode_counter_if #(.WIDTH(4)) ia ();
  mode_counter_if #(.WIDTH(4)) ib ();

  assign ia.en = en;  assign ia.load = load;  assign ia.load_val = load_val;
  assign ia.up_dn = up_dn;  assign ia.mode = mode;
  assign ib.en = en;  assign ib.load = load;  assign ib.load_val = load_val;
  assign ib.up_dn = up_dn;  assign ib.mode = mode;

  mode_counter #(.WIDTH(4), .MOD(10)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  mode_counter #(.WIDTH(4), .MOD(4))  dut_b (.clk(clk), .rst(rst), .bus(ib));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state, one slot per instance
  int mods [2] = '{10, 4};
  int m_cnt  [2];
  int m_dir  [2];
  int m_done [2];
  int m_wrap [2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(int k);
    int md, d, nxt;
    md = mods[k];
    d  = up_dn ? 1 : -1;
    if (rst) begin
      m_cnt[k] = 0; m_dir[k] = 1; m_done[k] = 0; m_wrap[k] = 0;
    end else if (load) begin
      m_cnt[k]  = (int'(load_val) < md) ? int'(load_val) : md - 1;
      m_done[k] = 0; m_wrap[k] = 0;
    end else begin
      m_wrap[k] = 0;
      if (en && m_done[k] == 0) begin
        if (mode == 2'b01) begin
          nxt = m_cnt[k] + d;
          if (nxt < 0 || nxt >= md) m_done[k] = 1;
          else m_cnt[k] = nxt;
        end else if (mode == 2'b10) begin
          nxt = m_cnt[k] + m_dir[k];
          if (nxt < 0 || nxt >= md) begin
            m_dir[k]  = -m_dir[k];
            nxt       = m_cnt[k] + m_dir[k];
            m_wrap[k] = 1;
          end
          m_cnt[k] = nxt;
        end else begin
          nxt = m_cnt[k] + d;
          if (nxt < 0 || nxt >= md) m_wrap[k] = 1;
          m_cnt[k] = (nxt + md) % md;
        end
      end
    end
  endtask

  function automatic int exp_tc(int k);
    int up;
    up = (mode == 2'b10) ? (m_dir[k] > 0) : int'(up_dn);
    return (m_cnt[k] == (up != 0 ? mods[k] - 1 : 0)) ? 1 : 0;
  endfunction

  // Model advances on each rising edge; DUT compared 1 time unit later
  initial begin
    forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      chk("a_cnt",  ia.cnt,  m_cnt[0]);
      chk("a_tc",   ia.tc,   exp_tc(0));
      chk("a_wrap", ia.wrap, m_wrap[0]);
      chk("a_done", ia.done, m_done[0]);
      chk("b_cnt",  ib.cnt,  m_cnt[1]);
      chk("b_tc",   ib.tc,   exp_tc(1));
      chk("b_wrap", ib.wrap, m_wrap[1]);
      chk("b_done", ib.done, m_done[1]);
`ifdef GRAY_OUT_EN
      chk("a_gray", ia.cnt_gray, m_cnt[0] ^ (m_cnt[0] >> 1));
      chk("b_gray", ib.cnt_gray, m_cnt[1] ^ (m_cnt[1] >> 1));
`endif
    end
  end

  task automatic apply(logic r, logic e, logic l, logic [3:0] lv, logic u, logic [1:0] m, int n);
    rst = r; en = e; load = l; load_val = lv; up_dn = u; mode = m;
    repeat (n) @(negedge clk);
  endtask

  int pp_cnt [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
  int pp_wrp [8] = '{0, 0, 0, 1, 0, 0, 1, 0};

  initial begin
    apply(1, 0, 0, 0, 1, 2'b00, 2);
    chk("lit_rst_cnt",  ia.cnt,  0);
    chk("lit_rst_wrap", ia.wrap, 0);
    chk("lit_rst_done", ia.done, 0);
    chk("lit_rst_tc",   ia.tc,   0);

    // free-run up, MOD=10
    apply(0, 1, 0, 0, 1, 2'b00, 9);
    chk("lit_fr_cnt9", ia.cnt, 9);
    chk("lit_fr_tc9",  ia.tc,  1);
    chk("lit_b_cnt1",  ib.cnt, 1);
    apply(0, 1, 0, 0, 1, 2'b00, 1);
    chk("lit_fr_wrapcnt", ia.cnt,  0);
    chk("lit_fr_wrap",    ia.wrap, 1);
    apply(0, 1, 0, 0, 1, 2'b00, 1);
    chk("lit_fr_cnt1",  ia.cnt,  1);
    chk("lit_fr_wrap0", ia.wrap, 0);

    // load then count down
    apply(0, 0, 1, 4'd2, 1, 2'b00, 1);
    chk("lit_ld2", ia.cnt, 2);
    apply(0, 1, 0, 0, 0, 2'b00, 2);
    chk("lit_dn_cnt0", ia.cnt, 0);
    chk("lit_dn_tc0",  ia.tc,  1);
    apply(0, 1, 0, 0, 0, 2'b00, 1);
    chk("lit_dn_cnt9", ia.cnt,  9);
    chk("lit_dn_wrap", ia.wrap, 1);
    apply(0, 1, 0, 0, 0, 2'b00, 1);
    chk("lit_dn_cnt8", ia.cnt, 8);

    // one-shot
    apply(0, 0, 1, 4'd7, 1, 2'b01, 1);
    chk("lit_os_ld7",  ia.cnt, 7);
    chk("lit_b_sat3",  ib.cnt, 3);
    apply(0, 1, 0, 0, 1, 2'b01, 2);
    chk("lit_os_cnt9",  ia.cnt,  9);
    chk("lit_os_done0", ia.done, 0);
    apply(0, 1, 0, 0, 1, 2'b01, 1);
    chk("lit_os_done1", ia.done, 1);
    chk("lit_os_hold",  ia.cnt,  9);
    apply(0, 1, 0, 0, 1, 2'b01, 2);
    apply(0, 1, 0, 0, 1, 2'b00, 1);
    chk("lit_os_frozen", ia.cnt, 9);
    apply(0, 0, 1, 4'd3, 1, 2'b01, 1);
    chk("lit_os_ld3",   ia.cnt,  3);
    chk("lit_os_clr",   ia.done, 0);
    apply(0, 1, 0, 0, 1, 2'b01, 1);
    chk("lit_os_resume", ia.cnt, 4);

    // ping-pong from reset, up_dn toggled every cycle
    apply(1, 0, 0, 0, 1, 2'b10, 1);
    for (int i = 0; i < 8; i++) begin
      apply(0, 1, 0, 0, logic'(i[0]), 2'b10, 1);
      chk($sformatf("lit_pp_cnt%0d", i), ib.cnt,  pp_cnt[i]);
      chk($sformatf("lit_pp_wrp%0d", i), ib.wrap, pp_wrp[i]);
    end

    // saturating load, load over en, reset over en, hold
    apply(0, 0, 1, 4'd12, 1, 2'b00, 1);
    chk("lit_sat9", ia.cnt, 9);
    apply(0, 1, 1, 4'd4, 1, 2'b00, 1);
    chk("lit_ld_wins", ia.cnt, 4);
    apply(0, 1, 0, 0, 1, 2'b00, 2);
    chk("lit_cnt6", ia.cnt, 6);
    apply(1, 1, 0, 0, 1, 2'b00, 1);
    chk("lit_rst_en", ia.cnt, 0);
    apply(0, 0, 1, 4'd5, 1, 2'b00, 1);
    apply(0, 0, 0, 0, 1, 2'b00, 3);
    chk("lit_hold5", ia.cnt, 5);
`ifdef GRAY_OUT_EN
    chk("lit_gray5", ia.cnt_gray, 4'b0111);
`endif
    apply(0, 1, 0, 0, 1, 2'b00, 1);
    chk("lit_cnt6b", ia.cnt, 6);
`ifdef GRAY_OUT_EN
    chk("lit_gray6", ia.cnt_gray, 4'b0101);
`endif

    // reserved mode behaves as free-run
    apply(0, 0, 1, 4'd0, 0, 2'b11, 1);
    apply(0, 1, 0, 0, 0, 2'b11, 1);
    chk("lit_m3_cnt",  ia.cnt,  9);
    chk("lit_m3_wrap", ia.wrap, 1);

    apply(0, 0, 0, 0, 1, 2'b00, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
Parametrised, fully synchronous counter that replaces the 4-bit negedge ripple counter for all new designs. Provides configurable width and modulus, up/down counting, parallel load, clock enable and three run modes: free-run wrap, one-shot and ping-pong. Used as a general tick/sequence counter feeding timers and address generators.

Parameters:
WIDTH, 8, counter width in bits.
MOD, 2**WIDTH, count range 0..MOD-1; legal range 2 <= MOD <= 2**WIDTH.

Ports:
clk  input  1  clock, rising edge, all state
rst  input  1  reset, synchronous, active-high
en  input  1  count enable
load  input  1  parallel load strobe
load_val  input  WIDTH  value for load
up_dn  input  1  1 = count up, 0 = count down; ignored in ping-pong mode
mode  input  2  00 = free-run, 01 = one-shot, 10 = ping-pong, 11 = reserved (behaves as 00)
cnt  output  WIDTH  registered count
tc  output  1  terminal-count level (combinational from registers)
wrap  output  1  registered 1-cycle wrap/bounce pulse
done  output  1  registered one-shot complete flag

Behaviour:
- Reset is synchronous and active-high. On rst: cnt=0, wrap=0, done=0, internal dir=up. tc follows from these values.
- Priority at each rising edge: rst > load > en. With en=0 and no load, all registers hold and wrap=0.
- Effective direction: up_dn in modes 00, 01 and 11; internal dir register in mode 10.
- Terminal value: MOD-1 when the effective direction is up, 0 when it is down.
- tc = (cnt == terminal value). It is a level and is independent of en.
- Load:
  - cnt <= load_val if load_val < MOD, otherwise cnt <= MOD-1 (saturating).
  - done <= 0, wrap <= 0, dir unchanged.
- Free-run (00/11), en=1:
  - cnt steps ±1.
  - Up from MOD-1 gives 0; down from 0 gives MOD-1. On either wrap, wrap=1 for exactly that cycle, coincident with the post-wrap cnt value.
- One-shot (01), en=1:
  - Steps ±1 while not at the terminal value.
  - At the terminal value: cnt holds and done <= 1. wrap is never asserted.
  - While done=1, counting is frozen regardless of en. Only load or rst clears done.
- Ping-pong (10), en=1:
  - dir=up at MOD-1: cnt <= MOD-2, dir <= down, wrap <= 1.
  - dir=down at 0: cnt <= 1, dir <= up, wrap <= 1.
  - Otherwise cnt steps in the direction of dir.
- Mode and up_dn changes take effect at the next enabled edge; cnt is not disturbed by the change.
- Entering ping-pong: dir keeps its last value (up after reset).
- Leaving one-shot with done=1: done stays set and counting remains frozen until load or rst.
- Latency: one cycle from en, load or rst to the updated cnt, wrap and done.

Optional Feature:
Macro GRAY_OUT_EN.
- Defined: adds output port cnt_gray (WIDTH bits, registered), equal to cnt ^ (cnt >> 1) in the same cycle as cnt. Its reset value is 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=4, MOD=10, mode=00, up_dn=1, en=1 after rst -> cnt 0,1,…,9,0,1. tc=1 only while cnt=9. wrap=1 only in the cycle cnt=0 following 9.
2. Same config, load load_val=2, then up_dn=0 -> cnt 2,1,0,9,8. wrap=1 with cnt=9. tc=1 while cnt=0.
3. mode=01, up, load 7 -> cnt 7,8,9,9,9. done rises the cycle after cnt first shows 9 and stays set with en=1. Then load 3 -> cnt=3, done=0, counting resumes.
4. MOD=4, mode=10 from reset -> cnt 0,1,2,3,2,1,0,1,2. wrap=1 in the cycles cnt=2 (after 3) and cnt=1 (after 0). Toggling up_dn has no effect.
5. MOD=10, load_val=12 -> cnt=9. Simultaneously, load=1, en=1, load_val=4 -> cnt=4 (load wins). rst asserted at cnt=6 with en=1 -> next cnt=0, done=0, wrap=0. en=0 -> cnt holds.
6. GRAY_OUT_EN defined, WIDTH=4, load 5 -> cnt=0101 and cnt_gray=0111 in the same cycle. Count to 6 -> cnt_gray=0101.
